// File: rtl/lag_pkg.sv
// rtl/lag_pkg.sv - shared FSM states and width/rounding helpers for the lag signal generator family
package lag_pkg;

    typedef enum logic [1:0] {
        LAG_IDLE  = 2'd0,
        LAG_MAC   = 2'd1,
        LAG_ROUND = 2'd2
    } lag_state_t;

    // Accumulator wide enough that NUM_TAPS full-width products never overflow
    function automatic int lag_acc_w(input int data_w, input int coef_w, input int num_taps);
        return data_w + coef_w + $clog2(num_taps);
    endfunction

    function automatic longint lag_round_const(input int frac);
        return (frac > 0) ? (64'sd1 <<< (frac - 1)) : 64'sd0;
    endfunction

endpackage

// File: rtl/lag_delay_line.sv
// rtl/lag_delay_line.sv - NUM_TAPS sample shift register with fill tracking and aligned copy of newest sample
module lag_delay_line #(
    parameter int DATA_W   = 16,
    parameter int NUM_TAPS = 4
) (
    input  logic                       clk_operation,
    input  logic                       rst,
    input  logic                       sample_valid,
    input  logic signed [DATA_W-1:0]   sample,
    output logic [NUM_TAPS*DATA_W-1:0] lag_flat,
    output logic                       primed,
    output logic signed [DATA_W-1:0]   signal_align
);

    localparam int                FILL_W = $clog2(NUM_TAPS + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(NUM_TAPS);

    logic [FILL_W-1:0] fill_count;

    // Tap 0 sits in the low slice; taps not yet written hold their reset value of 0
    always_ff @(posedge clk_operation) begin
        if (!rst) begin
            lag_flat     <= '0;
            fill_count   <= '0;
            signal_align <= '0;
        end else if (sample_valid) begin
            lag_flat     <= {lag_flat[(NUM_TAPS-1)*DATA_W-1:0], sample};
            signal_align <= sample;
            if (fill_count != FULL) begin
                fill_count <= fill_count + 1'b1;
            end
        end
    end

    assign primed = (fill_count == FULL);

endmodule

// File: rtl/lag_fir_generator.sv
// rtl/lag_fir_generator.sv - single-MAC weighted-sum lag generator; LAG_FIR_SATURATE_EN selects clamping over wrap
module lag_fir_generator
    import lag_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 14,
    parameter int NUM_TAPS  = 4
) (
    input  logic                       clk_operation,
    input  logic                       rst,
    input  logic                       sample_valid,
    input  logic signed [DATA_W-1:0]   sample,
    input  logic [NUM_TAPS*COEF_W-1:0] coef_flat,
    input  logic                       start,
    output logic                       busy,
    output logic                       primed,
    output logic signed [DATA_W-1:0]   signal_align,
    output logic signed [DATA_W-1:0]   signal_lag,
    output logic                       result_valid,
    output logic                       sat_flag
);

    localparam int ACC_W = lag_acc_w(DATA_W, COEF_W, NUM_TAPS);
    localparam int SUM_W = ACC_W + 1;
    localparam int IDX_W = $clog2(NUM_TAPS);
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_TAPS - 1);
    localparam logic signed [SUM_W-1:0] RND      = SUM_W'(lag_round_const(COEF_FRAC));

    lag_state_t                     state, state_nxt;
    logic [NUM_TAPS*DATA_W-1:0]     lag_flat;
    logic [NUM_TAPS*DATA_W-1:0]     snap_data;
    logic [NUM_TAPS*COEF_W-1:0]     snap_coef;
    logic signed [ACC_W-1:0]        acc;
    logic [IDX_W-1:0]               idx;
    logic signed [DATA_W+COEF_W-1:0] product;
    logic signed [SUM_W-1:0]        acc_rnd;
    logic signed [DATA_W-1:0]       r_reduced;
    logic                           r_clipped;

    lag_delay_line #(
        .DATA_W   (DATA_W),
        .NUM_TAPS (NUM_TAPS)
    ) u_delay_line (
        .clk_operation (clk_operation),
        .rst           (rst),
        .sample_valid  (sample_valid),
        .sample        (sample),
        .lag_flat      (lag_flat),
        .primed        (primed),
        .signal_align  (signal_align)
    );

    always_ff @(posedge clk_operation) begin
        if (!rst) begin
            state <= LAG_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LAG_IDLE:  if (start) state_nxt = LAG_MAC;
            LAG_MAC:   if (idx == LAST_IDX) state_nxt = LAG_ROUND;
            LAG_ROUND: state_nxt = LAG_IDLE;
            default:   state_nxt = LAG_IDLE;
        endcase
    end

    assign busy    = (state != LAG_IDLE);
    assign product = $signed(snap_data[idx*DATA_W +: DATA_W]) * $signed(snap_coef[idx*COEF_W +: COEF_W]);
    assign acc_rnd = {acc[ACC_W-1], acc} + RND;

`ifdef LAG_FIR_SATURATE_EN
    localparam int R_W = SUM_W - COEF_FRAC;
    logic signed [R_W-1:0] r;
    logic                  hi_ones, hi_zeros;

    // In range exactly when all bits above the result sign agree with it
    always_comb begin
        r         = R_W'(acc_rnd >>> COEF_FRAC);
        hi_ones   = &r[R_W-1:DATA_W-1];
        hi_zeros  = ~|r[R_W-1:DATA_W-1];
        r_clipped = !(hi_ones || hi_zeros);
        if (!r_clipped) begin
            r_reduced = r[DATA_W-1:0];
        end else if (r[R_W-1]) begin
            r_reduced = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            r_reduced = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    assign r_reduced = DATA_W'(acc_rnd >>> COEF_FRAC);
    assign r_clipped = 1'b0;
`endif

    always_ff @(posedge clk_operation) begin
        if (!rst) begin
            snap_data    <= '0;
            snap_coef    <= '0;
            acc          <= '0;
            idx          <= '0;
            signal_lag   <= '0;
            result_valid <= 1'b0;
            sat_flag     <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            sat_flag     <= 1'b0;
            case (state)
                LAG_IDLE: begin
                    // A sample landing on the start edge is folded into the snapshot
                    if (start) begin
                        snap_data <= sample_valid ? {lag_flat[(NUM_TAPS-1)*DATA_W-1:0], sample} : lag_flat;
                        snap_coef <= coef_flat;
                        acc       <= '0;
                        idx       <= '0;
                    end
                end
                LAG_MAC: begin
                    acc <= acc + ACC_W'(product);
                    idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
                LAG_ROUND: begin
                    signal_lag   <= r_reduced;
                    result_valid <= 1'b1;
                    sat_flag     <= r_clipped;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lag_fir_generator.sv
// tb/tb_lag_fir_generator.sv - scoreboard bench for lag_fir_generator at 4 and 8 taps
module tb_lag_fir_generator;

    logic               clk = 1'b0;
    logic               rst;
    logic               sample_valid, start;
    logic signed [15:0] sample;
    logic [63:0]        coef_flat;
    logic               busy, primed, result_valid, sat_flag;
    logic signed [15:0] signal_align, signal_lag;

    logic               sample_valid8, start8;
    logic signed [15:0] sample8;
    logic [127:0]       coef_flat8;
    logic               busy8, primed8, result_valid8, sat_flag8;
    logic signed [15:0] signal_align8, signal_lag8;

    typedef struct {
        int lag;
        int sat;
        int start_edge;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb8_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    lag_fir_generator u_dut (
        .clk_operation (clk),
        .rst           (rst),
        .sample_valid  (sample_valid),
        .sample        (sample),
        .coef_flat     (coef_flat),
        .start         (start),
        .busy          (busy),
        .primed        (primed),
        .signal_align  (signal_align),
        .signal_lag    (signal_lag),
        .result_valid  (result_valid),
        .sat_flag      (sat_flag)
    );

    lag_fir_generator #(.NUM_TAPS(8)) u_dut8 (
        .clk_operation (clk),
        .rst           (rst),
        .sample_valid  (sample_valid8),
        .sample        (sample8),
        .coef_flat     (coef_flat8),
        .start         (start8),
        .busy          (busy8),
        .primed        (primed8),
        .signal_align  (signal_align8),
        .signal_lag    (signal_lag8),
        .result_valid  (result_valid8),
        .sat_flag      (sat_flag8)
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin : mon4
        exp_t e;
        if (rst && result_valid) begin
            check("pulse_width", int'(prev_valid), 0);
            if (sb_q.size() == 0) begin
                check("unexpected_result_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("signal_lag", signal_lag, e.lag);
                check("sat_flag", int'(sat_flag), e.sat);
                check("latency", cycle - e.start_edge, 5);
            end
        end
        prev_valid = rst && result_valid;
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (rst && result_valid8) begin
            if (sb8_q.size() == 0) begin
                check("unexpected_result_valid8", 1, 0);
            end else begin
                e = sb8_q.pop_front();
                check("signal_lag8", signal_lag8, e.lag);
                check("sat_flag8", int'(sat_flag8), e.sat);
                check("latency8", cycle - e.start_edge, 9);
            end
        end
    end

    task automatic push4(input int lag, input int sat);
        exp_t e;
        e.lag = lag;
        e.sat = sat;
        e.start_edge = cycle + 1;
        sb_q.push_back(e);
    endtask

    task automatic sample4(input int s);
        sample = 16'(s);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic start4(input int lag, input int sat);
        push4(lag, sat);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sb_q.size() != 0 || sb8_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0 || sb8_q.size() != 0) begin
            check("drain_timeout", sb_q.size() + sb8_q.size(), 0);
            sb_q.delete();
            sb8_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e8;
        rst = 1'b0;
        sample_valid = 1'b0; start = 1'b0; sample = '0; coef_flat = '0;
        sample_valid8 = 1'b0; start8 = 1'b0; sample8 = '0; coef_flat8 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_primed", int'(primed), 0);
        check("rst_signal_lag", signal_lag, 0);
        check("rst_signal_align", signal_align, 0);
        check("rst_result_valid", int'(result_valid), 0);
        rst = 1'b1;
        @(negedge clk);

        // Basic weighted sum: 400*0.25 + 300*0.5 + 200*0.25 = 300
        coef_flat = {16'sd0, 16'sd4096, 16'sd8192, 16'sd4096};
        sample4(100); sample4(200); sample4(300);
        check("primed_3_of_4", int'(primed), 0);
        sample4(400);
        check("primed_full", int'(primed), 1);
        check("align_400", signal_align, 400);
        start4(300, 0);
        check("busy_after_start", int'(busy), 1);
        drain(20);
        check("busy_after_result", int'(busy), 0);

        // Rounding half toward +inf: 1.5 -> 2, -1.5 -> -1
        coef_flat = {16'sd0, 16'sd0, 16'sd0, 16'sd8192};
        sample4(3);
        start4(2, 0);
        drain(20);
        sample4(-3);
        start4(-1, 0);
        drain(20);

        // Full-scale sum of 4 * 32767 * 1.0 = 131068
        coef_flat = {4{16'sd16384}};
        repeat (4) sample4(32767);
`ifdef LAG_FIR_SATURATE_EN
        start4(32767, 1);
`else
        start4(-4, 0);
`endif
        drain(20);

        // Start with a coincident sample, then a sample and a stray start during MAC
        coef_flat = {16'sd0, 16'sd0, 16'sd0, 16'sd16384};
        push4(500, 0);
        sample = 16'sd500; sample_valid = 1'b1; start = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        sample = 16'sd777; sample_valid = 1'b1; start = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0; start = 1'b0;
        check("align_during_mac", signal_align, 777);
        check("busy_during_mac", int'(busy), 1);
        drain(20);
        repeat (8) @(negedge clk);
        check("busy_idle_after_stray", int'(busy), 0);

        // Reset on the second MAC edge aborts the computation
        check("pre_reset_lag", signal_lag, 500);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_busy", int'(busy), 0);
        check("abort_primed", int'(primed), 0);
        check("abort_signal_lag", signal_lag, 0);
        check("abort_signal_align", signal_align, 0);
        repeat (8) @(negedge clk);
        start4(0, 0);
        drain(20);

        // Eight taps, only one filled
        coef_flat8 = '0;
        coef_flat8[15:0] = 16'd16384;
        sample8 = 16'sd1000; sample_valid8 = 1'b1;
        @(negedge clk);
        sample_valid8 = 1'b0;
        check("primed8_partial", int'(primed8), 0);
        check("align8", signal_align8, 1000);
        e8.lag = 1000; e8.sat = 0; e8.start_edge = cycle + 1;
        sb8_q.push_back(e8);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("busy8_after_start", int'(busy8), 1);
        drain(30);
        check("primed8_after", int'(primed8), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lag_fir_generator.md
Name: lag_fir_generator

Overview:
Parametrised successor of the 4-tap lag signal generator used for echo-cancellation testbenches.
- Keeps a NUM_TAPS-deep delay line of signed fixed-point samples.
- On request, computes one weighted sum of the delay-line contents using a single sequential multiply-accumulate (MAC).
- Emits the result as the synthetic lag signal, plus a sample-aligned copy of the newest input.
- Replaces the fixed 4-lag floating-point version with a configurable-depth, fixed-point, single-multiplier datapath that supports rounding and a fill tracker.

Parameters:
DATA_W, 16, signed sample and result width
COEF_W, 16, signed coefficient width
COEF_FRAC, 14, fractional bits of coefficients (Q(COEF_W-COEF_FRAC).COEF_FRAC)
NUM_TAPS, 4, delay-line depth, ≥2

Ports:
clk_operation  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-low reset (0 = reset)
sample_valid  in  1  capture sample into delay line this cycle
sample  in  DATA_W  signed input sample
coef_flat  in  NUM_TAPS*COEF_W  tap k coefficient at [k*COEF_W +: COEF_W]; tap 0 = newest
start  in  1  request one weighted-sum computation
busy  out  1  computation in progress
primed  out  1  delay line fully filled (fill_count == NUM_TAPS)
signal_align  out  DATA_W  newest accepted sample
signal_lag  out  DATA_W  last computed weighted sum
result_valid  out  1  one-cycle pulse when signal_lag updates
sat_flag  out  1  result clipped (valid with result_valid)

Behaviour:
- Reset (rst=0 at an edge):
  - state IDLE; all delay-line entries and snapshot cleared to 0; fill_count=0.
  - All outputs 0.
  - Reset mid-computation aborts it; no result_valid is issued.
- Sample path (any state):
  - sample_valid=1 shifts the delay line: lag[k] <= lag[k-1], lag[0] <= sample.
  - signal_align <= sample on the same edge.
  - fill_count increments, saturating at NUM_TAPS.
  - Unfilled taps read as 0.
- FSM: IDLE -> MAC -> ROUND -> IDLE.
  - IDLE: start=1 at edge E0:
    - Snapshot the delay line and coef_flat into working registers.
    - If sample_valid is also 1, the snapshot includes the new sample.
    - acc=0, tap index=0, busy<=1, go to MAC.
  - MAC: one tap per cycle. Edges E1..E_NUM_TAPS: acc += snap[i]*coef[i]; index wraps to 0 after NUM_TAPS-1, then go to ROUND.
  - ROUND (edge E_NUM_TAPS+1):
    - r = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC (round half toward +inf).
    - Reduce r to DATA_W per the Optional Feature.
    - signal_lag <= reduced value; result_valid<=1 for exactly one cycle; busy<=0; go to IDLE.
- Latency: result_valid is high in the cycle after edge E0+NUM_TAPS+1, i.e. NUM_TAPS+1 cycles after start is sampled.
- A new start may be accepted in the cycle result_valid is high.
- start while busy=1: ignored, no queuing.
- Samples arriving during MAC/ROUND update the live delay line only; the snapshot is unaffected.
- start with primed=0 is legal; missing taps contribute 0.
- Width rules:
  - Products are full DATA_W+COEF_W bits, signed.
  - acc width ACC_W = DATA_W+COEF_W+clog2(NUM_TAPS); no internal overflow.
  - Arithmetic shift.

Optional Feature:
Macro LAG_FIR_SATURATE_EN.
- Defined: r clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. sat_flag=1 with result_valid when clamping occurred, else 0.
- Undefined: r truncates to its low DATA_W bits (two's-complement wrap); sat_flag tied 0.

Decomposition:
- Package lag_pkg:
  - FSM state enum (LAG_IDLE, LAG_MAC, LAG_ROUND).
  - ACC_W computation function and rounding-constant helper, reused by the future adaptive-canceller blocks.
- One sub-module, lag_delay_line, holds:
  - NUM_TAPS shift register, fill counter, primed, signal_align.
  - Parallel flattened output to the MAC FSM.

Test Plan:
- Default params; coefs {4096,8192,4096,0}; samples 100,200,300,400 via sample_valid; then start -> primed=1, signal_lag=300, result_valid exactly 5 cycles after start, single-cycle pulse.
- Rounding: coef0=8192, others 0. Sample 3 then start -> signal_lag=2. Sample -3 then start -> signal_lag=-1.
- Saturation, all coefs 16384, four samples of 32767, start:
  - With LAG_FIR_SATURATE_EN: signal_lag=32767, sat_flag=1.
  - Without: signal_lag=-4, sat_flag=0.
- Concurrency:
  - start and sample_valid (sample=500) in the same cycle -> snapshot includes 500.
  - A sample_valid during MAC changes signal_align only; result is unchanged.
  - start during busy is ignored; exactly one result_valid.
- Reset mid-MAC: rst=0 at cycle 2 of MAC -> no result_valid; busy, primed, signal_lag, signal_align = 0; next start before any sample -> signal_lag=0.
- NUM_TAPS=8, one sample of 1000, coef0=16384, start -> primed=0, signal_lag=1000, latency 9 cycles.
